// File: rtl/prbs22_checker.sv
// prbs22_checker: serial PRBS-22 (x^22 + x^21 + 1) receiver/checker.
// Self-synchronises to the incoming MSB-first stream, then free-runs a
// local reference, flags mismatches and keeps error/bit statistics.
// Optional feature macro: PRBS_CHK_BITCNT_EN (48-bit bit_count). When the
// macro is undefined, bit_count is tied to zero.
module prbs22_checker #(
   parameter int LOCK_MATCHES = 32,
   parameter int WINDOW       = 64,
   parameter int LOL_ERRORS   = 8,
   parameter int ERR_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             clear_counts,
   output logic             locked,
   output logic             error_pulse,
   output logic             lol_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [47:0]      bit_count
);

   localparam logic [7:0]  LOCK_MATCHES_C = 8'(LOCK_MATCHES);
   localparam logic [15:0] WINDOW_C       = 16'(WINDOW);
   localparam logic [15:0] LOL_ERRORS_C   = 16'(LOL_ERRORS);

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [21:0]        r_q, r_d;
   logic [4:0]         fill_q, fill_d;
   logic [7:0]         match_q, match_d;
   logic [15:0]        win_cnt_q, win_cnt_d;
   logic [15:0]        win_err_q, win_err_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               errp_q, errp_d;
   logic               lolp_q, lolp_d;
   logic               locked_q, locked_d;
   logic               pred;
   logic               mism;
   logic               err_inc;

   // Predicted next bit from the two oldest history bits (generator taps).
   assign pred = r_q[20] ^ r_q[21];
   assign mism = bit_in ^ pred;

   // State, history, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_FILL;
         r_q       <= '0;
         fill_q    <= '0;
         match_q   <= '0;
         win_cnt_q <= '0;
         win_err_q <= '0;
         err_q     <= '0;
         errp_q    <= 1'b0;
         lolp_q    <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         win_cnt_q <= win_cnt_d;
         win_err_q <= win_err_d;
         err_q     <= err_d;
         errp_q    <= errp_d;
         lolp_q    <= lolp_d;
         locked_q  <= locked_d;
      end
   end

   // Next-state: fill history, hunt for lock, then check against the reference.
   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      fill_d    = fill_q;
      match_d   = match_q;
      win_cnt_d = win_cnt_q;
      win_err_d = win_err_q;
      errp_d    = 1'b0;
      lolp_d    = 1'b0;
      err_inc   = 1'b0;
      if (bit_valid) begin
         case (state_q)
            ST_FILL: begin
               r_d = {r_q[20:0], bit_in};
               if (fill_q == 5'd21) begin
                  fill_d  = '0;
                  match_d = '0;
                  state_d = ST_SYNC;
               end else begin
                  fill_d = fill_q + 5'd1;
               end
            end
            ST_SYNC: begin
               // Always take the line bit so the history re-aligns itself.
               r_d = {r_q[20:0], bit_in};
               if (!mism && (r_q != '0)) begin
                  if (match_q + 8'd1 == LOCK_MATCHES_C) begin
                     match_d   = '0;
                     win_cnt_d = '0;
                     win_err_d = '0;
                     state_d   = ST_LOCKED;
                  end else begin
                     match_d = match_q + 8'd1;
                  end
               end else begin
                  match_d = '0;
               end
            end
            ST_LOCKED: begin
               // Free-run on the prediction so one line error costs one error.
               r_d = {r_q[20:0], pred};
               if (mism) begin
                  errp_d  = 1'b1;
                  err_inc = 1'b1;
               end
               if (mism && (win_err_q + 16'd1 == LOL_ERRORS_C)) begin
                  state_d   = ST_FILL;
                  lolp_d    = 1'b1;
                  fill_d    = '0;
                  r_d       = r_q;
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else if (win_cnt_q + 16'd1 == WINDOW_C) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + 16'd1;
                  win_err_d = win_err_q + {15'd0, mism};
               end
            end
            default: begin
               state_d = ST_FILL;
               fill_d  = '0;
            end
         endcase
      end
      locked_d = (state_d == ST_LOCKED);
      // Clear wins over a simultaneous increment; count saturates.
      if (clear_counts)
         err_d = '0;
      else if (err_inc && (err_q != '1))
         err_d = err_q + ERR_W'(1);
      else
         err_d = err_q;
   end

   assign locked      = locked_q;
   assign error_pulse = errp_q;
   assign lol_pulse   = lolp_q;
   assign err_count   = err_q;

`ifdef PRBS_CHK_BITCNT_EN
   logic [47:0] bitcnt_q;
   logic        bit_inc;

   assign bit_inc = bit_valid && (state_q == ST_LOCKED);

   // Saturating count of valid bits checked while locked.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bitcnt_q <= '0;
      else if (clear_counts)
         bitcnt_q <= '0;
      else if (bit_inc && (bitcnt_q != '1))
         bitcnt_q <= bitcnt_q + 48'd1;
   end

   assign bit_count = bitcnt_q;
`else
   assign bit_count = '0;
`endif

endmodule

// File: tb/tb_prbs22_checker.sv
// Testbench for prbs22_checker: directed scenarios driven from a reference
// PRBS-22 generator (seed 22'h363D7F), default parameters.
module tb_prbs22_checker;

   logic        clk;
   logic        reset;
   logic        bit_in;
   logic        bit_valid;
   logic        clear_counts;
   logic        locked;
   logic        error_pulse;
   logic        lol_pulse;
   logic [31:0] err_count;
   logic [47:0] bit_count;

   logic [21:0] gen;
   int          checks;
   int          failures;

   prbs22_checker dut (
      .clk          (clk),
      .reset        (reset),
      .bit_in       (bit_in),
      .bit_valid    (bit_valid),
      .clear_counts (clear_counts),
      .locked       (locked),
      .error_pulse  (error_pulse),
      .lol_pulse    (lol_pulse),
      .err_count    (err_count),
      .bit_count    (bit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] bc_exp(input logic [63:0] v);
`ifdef PRBS_CHK_BITCNT_EN
      return v;
`else
      return 64'd0 & v;
`endif
   endfunction

   // One clock with the given inputs; outputs are then sampled 1 time unit after the edge.
   task automatic send(input logic b, input logic v);
      bit_in    = b;
      bit_valid = v;
      @(posedge clk);
      #1;
   endtask

   // Next generator bit (MSB first), optionally flipped on the line.
   task automatic send_gen(input logic flip);
      logic b;
      b   = gen[21];
      gen = {gen[20:0], gen[21] ^ gen[20]};
      send(b ^ flip, 1'b1);
   endtask

   // Send clean bits until locked; n = bit index at which lock was seen (0 = never).
   task automatic clean_until_lock(input int limit, output int n);
      n = 0;
      for (int i = 1; i <= limit; i++) begin
         send_gen(1'b0);
         if (locked && n == 0) n = i;
         if (n != 0) break;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bit_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      gen = 22'h363D7F;
   endtask

   initial begin
      int n;
      int epulses;
      int vcnt;
      bit ever_locked;
      checks       = 0;
      failures     = 0;
      bit_in       = 1'b0;
      bit_valid    = 1'b0;
      clear_counts = 1'b0;
      gen          = 22'h363D7F;

      // Reset state
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", locked, 0);
      chk("rst_errp", error_pulse, 0);
      chk("rst_lolp", lol_pulse, 0);
      chk("rst_errcnt", err_count, 0);
      chk("rst_bitcnt", bit_count, 0);
      reset = 1'b0;
      $display("txn reset: outputs idle");

      // Clean stream: lock at valid bit 54, no errors over 10,000 bits
      clean_until_lock(100, n);
      chk("clean_lock_idx", n, 54);
      epulses = 0;
      for (int i = 54; i < 10000; i++) begin
         send_gen(1'b0);
         if (error_pulse) epulses++;
      end
      chk("clean_errpulses", epulses, 0);
      chk("clean_errcnt", err_count, 0);
      chk("clean_locked", locked, 1);
      chk("clean_bitcnt", bit_count, bc_exp(9946));
      $display("txn clean: lock_idx=%0d err_count=%0d bit_count=%0d", n, err_count, bit_count);

      // Single flipped bit while locked
      send_gen(1'b1);
      chk("flip_errp", error_pulse, 1);
      chk("flip_errcnt", err_count, 1);
      chk("flip_locked", locked, 1);
      chk("flip_bitcnt", bit_count, bc_exp(9947));
      send_gen(1'b0);
      chk("flip_errp_after", error_pulse, 0);
      chk("flip_errcnt_after", err_count, 1);
      $display("txn single flip: err_count=%0d locked=%0b", err_count, locked);

      // clear_counts coincident with an error
      clear_counts = 1'b1;
      send_gen(1'b1);
      clear_counts = 1'b0;
      chk("clr_errp", error_pulse, 1);
      chk("clr_errcnt", err_count, 0);
      chk("clr_bitcnt", bit_count, 0);
      send_gen(1'b0);
      chk("clr_bitcnt_next", bit_count, bc_exp(1));
      chk("clr_locked", locked, 1);
      $display("txn clear+error: err_count=%0d bit_count=%0d", err_count, bit_count);

      // Reset while locked
      reset = 1'b1;
      send_gen(1'b1);
      chk("midrst_locked", locked, 0);
      chk("midrst_errp", error_pulse, 0);
      chk("midrst_lolp", lol_pulse, 0);
      chk("midrst_errcnt", err_count, 0);
      chk("midrst_bitcnt", bit_count, 0);
      reset = 1'b0;
      gen = 22'h363D7F;
      $display("txn reset while locked: outputs idle");

      // Eight consecutive flips right after lock force loss of lock, then re-lock
      clean_until_lock(100, n);
      chk("lol_first_lock", n, 54);
      for (int i = 1; i <= 7; i++) begin
         send_gen(1'b1);
         chk("lol_errp", error_pulse, 1);
         chk("lol_pre_lolp", lol_pulse, 0);
      end
      chk("lol_pre_locked", locked, 1);
      send_gen(1'b1);
      chk("lol_errp8", error_pulse, 1);
      chk("lol_pulse8", lol_pulse, 1);
      chk("lol_locked8", locked, 0);
      chk("lol_errcnt8", err_count, 8);
      clean_until_lock(100, n);
      chk("lol_relock_idx", n, 54);
      chk("lol_errcnt_kept", err_count, 8);
      $display("txn loss of lock: relock_idx=%0d err_count=%0d", n, err_count);

      // Constant zero stream never locks
      do_reset();
      ever_locked = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         send(1'b0, 1'b1);
         if (locked) ever_locked = 1'b1;
      end
      chk("zero_locked", ever_locked, 0);
      chk("zero_errcnt", err_count, 0);
      $display("txn all-zero stream: ever_locked=%0b", ever_locked);

      // bit_valid pattern 1-0-0-1 with garbage on stall cycles
      do_reset();
      vcnt = 0;
      n = 0;
      epulses = 0;
      for (int c = 0; c < 400 && n == 0; c++) begin
         if ((c % 4 == 0) || (c % 4 == 3)) begin
            send_gen(1'b0);
            vcnt++;
            if (locked) n = vcnt;
         end else begin
            send(1'($urandom), 1'b0);
            if (locked) n = -1;
         end
         if (error_pulse) epulses++;
      end
      chk("stall_lock_idx", n, 54);
      chk("stall_errpulses", epulses, 0);
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      chk("stall_hold_locked", locked, 1);
      chk("stall_hold_bitcnt", bit_count, 0);
      $display("txn valid gaps: lock after %0d valid bits", n);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prbs22_checker.md
# prbs22_checker

Serial PRBS-22 receiver/checker: the far end of the 22-bit LFSR pattern generator (polynomial x^22 + x^21 + 1, MSB-first serial output). It self-synchronises to the incoming bit stream, then free-runs a local reference LFSR, flags every mismatching bit, and keeps error and bit statistics. It sits on the receive side of the link loopback path, beside the generator.

## Interface
- LOCK_MATCHES, 32: consecutive correct predictions required to declare lock (1..255)
- WINDOW, 64: loss-of-lock observation window in valid bits (2..65535)
- LOL_ERRORS, 8: errors within one window that force loss of lock (1..WINDOW)
- ERR_W, 32: err_count width

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- bit_in  in  1  received serial bit, generator MSB-first order
- bit_valid  in  1  bit_in qualifier; bits with bit_valid=0 are ignored entirely
- clear_counts  in  1  synchronous clear of err_count and bit_count
- locked  out  1  high while in LOCKED
- error_pulse  out  1  one-cycle pulse per mismatching bit while LOCKED
- lol_pulse  out  1  one-cycle pulse on LOCKED -> FILL transition
- err_count  out  ERR_W  saturating count of mismatches while LOCKED
- bit_count  out  48  saturating count of valid bits checked while LOCKED

## Operation
- History register r[21:0], r[0] newest. Predicted bit p = r[20] ^ r[21]; same taps as the generator, so b(n+22) = b(n+1) ^ b(n).
- Every action below happens only on cycles with bit_valid=1.
- FILL: shift bit_in into r[0]; fill counter 0..21; after the 22nd bit go to SYNC, match counter = 0.
- SYNC: compare bit_in to p; always shift bit_in into r (self-synchronising). Match with r != 0 increments match counter; mismatch, or r == 0, clears it. When the match counter reaches LOCK_MATCHES -> LOCKED; window and window-error counters cleared.
- LOCKED: shift p (not bit_in) into r, so a single line error produces exactly one error. bit_in != p -> error_pulse, err_count+1, window-error+1. Each valid bit -> bit_count+1, window counter+1.
- Window: when the window counter reaches WINDOW it restarts at 0 and window-error clears. If window-error reaches LOL_ERRORS -> FILL, lol_pulse, fill counter 0, r unchanged.
- err_count and bit_count saturate at all-ones; they hold value across lock loss.
- clear_counts=1 zeroes both counters that cycle and has priority over a simultaneous increment; error_pulse still fires.
- All-zero stream never locks (r == 0 blocks matches).

## Timing
- Reset values: state FILL, r=0, all internal counters 0, locked=0, error_pulse=0, lol_pulse=0, err_count=0, bit_count=0.
- All outputs registered. error_pulse, counter updates and lol_pulse become visible the cycle after the clock edge that samples the offending valid bit.
- locked rises the cycle after the edge sampling the LOCK_MATCHES-th matching bit; with a clean stream from reset, that is valid bit 22 + LOCK_MATCHES (54 with defaults).
- locked falls on the same edge that pulses lol_pulse.
- Reset asserted mid-operation returns everything to reset values immediately; no partial state survives.
- bit_valid may be low for arbitrarily long stretches; state is held.

## Configuration
- PRBS_CHK_BITCNT_EN defined: 48-bit bit_count implemented as above.
- Undefined: counter logic removed; bit_count is tied to 0. All other behaviour is identical.

## Test plan
- Clean stream from generator seed 22'h363D7F, bit_valid=1 continuously -> locked rises after valid bit 54; err_count stays 0 over 10,000 bits; bit_count = bits sent after lock.
- Locked, single bit flipped -> exactly one error_pulse, err_count=1, locked stays 1.
- Locked, 8 flips within 64 bits -> lol_pulse once on the 8th, locked=0, then re-lock after 54 further clean bits; err_count=8 retained.
- Constant 0 input, 1,000 bits -> locked never asserts, err_count=0.
- bit_valid toggling 1-0-0-1 on a clean stream -> lock after 54 valid bits; stall cycles change nothing.
- clear_counts coincident with an injected error -> error_pulse=1, err_count=0 next cycle; reset asserted while locked -> all outputs 0 next cycle.
